// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and constants for the result-broadcast ring
// Purpose: packet layout carried on the ring, field widths, and ring stop positions.
// Ports: none (package).
package ring_pkg;

  localparam int RING_XLEN          = 32;
  localparam int RING_PHYS_REG_SIZE = 256;
  localparam int RING_ROB_ENTRY     = 256;
  localparam int RING_PW            = $clog2(RING_PHYS_REG_SIZE);
  localparam int RING_RW            = $clog2(RING_ROB_ENTRY);

  // 'reg' is a keyword, so the destination tag field is phys_reg.
  typedef struct packed {
    logic [RING_PW-1:0]   phys_reg;
    logic [RING_XLEN-1:0] val;
    logic [RING_RW-1:0]   rob_entry;
  } ring_pkt_t;

  typedef enum logic [2:0] {
    RING_ROB      = 3'd0,
    RING_LOGICAL  = 3'd1,
    RING_ARITH    = 3'd2,
    RING_BRANCH   = 3'd3,
    RING_LD_ST    = 3'd4,
    RING_MUL_DIV  = 3'd5,
    RING_REG_FILE = 3'd6
  } ring_pos_e;

endpackage

// File: rtl/ring_tx_fifo.sv
// rtl/ring_tx_fifo.sv - circular buffer of ring packets for one ring stop
// Purpose: DEPTH-entry FIFO with push/pop/flush and a combinational head view.
// Ports: clk, rst (async, active-high), flush, push + push_data, pop,
//        head_data (entry at head), count (occupancy).
// The caller guarantees no push when full, no pop when empty, and no push with flush.
module ring_tx_fifo
  import ring_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  ring_pkt_t                  push_data,
  input  logic                       pop,
  output ring_pkt_t                  head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ring_pkt_t     mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap from DEPTH-1 to 0 for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/ring_stop_tx.sv
// rtl/ring_stop_tx.sv - FU result injection port for one stop on the result ring
// Purpose: buffers FU results and injects one per cycle into empty ring slots.
// Optional feature macro: RING_TX_BYPASS_EN (empty-FIFO results go straight to the ring).
// Ports: clk, rst (async, active-high), flush;
//        fu_valid/fu_ready/fu_reg/fu_val/fu_rob_entry - result offer from the FU;
//        slot_busy - ring slot arriving next edge is occupied;
//        ring_valid/ring_reg/ring_val/ring_rob_entry - registered injection;
//        count - FIFO occupancy; starve - head blocked for STARVE_LIMIT cycles.
module ring_stop_tx
  import ring_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int PHYS_REG_SIZE = 256,
  parameter int ROB_ENTRY     = 256,
  parameter int DEPTH         = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             fu_valid,
  output logic                             fu_ready,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] fu_reg,
  input  logic [XLEN-1:0]                  fu_val,
  input  logic [$clog2(ROB_ENTRY)-1:0]     fu_rob_entry,
  input  logic                             slot_busy,
  output logic                             ring_valid,
  output logic [$clog2(PHYS_REG_SIZE)-1:0] ring_reg,
  output logic [XLEN-1:0]                  ring_val,
  output logic [$clog2(ROB_ENTRY)-1:0]     ring_rob_entry,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             starve
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  ring_pkt_t     in_pkt;
  ring_pkt_t     head_pkt;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [SW-1:0] starve_cnt;

  assign in_pkt = '{phys_reg: fu_reg, val: fu_val, rob_entry: fu_rob_entry};

  // Space is judged on the current count only; a same-cycle pop does not free a slot.
  assign fu_ready = !rst && !flush && (count < CW'(DEPTH));
  assign pop      = (count != '0) && !slot_busy && !flush;

`ifdef RING_TX_BYPASS_EN
  // Only with an empty FIFO, so a bypassing result can never overtake a buffered one.
  assign bypass = (count == '0) && fu_valid && fu_ready && !slot_busy && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = fu_valid && fu_ready && !bypass;

  ring_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (in_pkt),
    .pop       (pop),
    .head_data (head_pkt),
    .count     (count)
  );

  // Data registers only load on an injection; otherwise they keep the last packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_valid     <= 1'b0;
      ring_reg       <= '0;
      ring_val       <= '0;
      ring_rob_entry <= '0;
    end else begin
      ring_valid <= pop || bypass;
      if (pop) begin
        ring_reg       <= head_pkt.phys_reg;
        ring_val       <= head_pkt.val;
        ring_rob_entry <= head_pkt.rob_entry;
      end else if (bypass) begin
        ring_reg       <= in_pkt.phys_reg;
        ring_val       <= in_pkt.val;
        ring_rob_entry <= in_pkt.rob_entry;
      end
    end
  end

  // Counts consecutive edges where a buffered head was refused by a busy slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (flush || pop || (count == '0)) begin
      starve_cnt <= '0;
    end else if (slot_busy && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve = (starve_cnt == SW'(STARVE_LIMIT));

endmodule

// File: tb/tb_ring_stop_tx.sv
// tb/tb_ring_stop_tx.sv - self-checking bench for ring_stop_tx against a queue model
module tb_ring_stop_tx;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef RING_TX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fu_valid;
  logic        fu_ready;
  logic [7:0]  fu_reg;
  logic [31:0] fu_val;
  logic [7:0]  fu_rob_entry;
  logic        slot_busy;
  logic        ring_valid;
  logic [7:0]  ring_reg;
  logic [31:0] ring_val;
  logic [7:0]  ring_rob_entry;
  logic [2:0]  count;
  logic        starve;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ring_stop_tx dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_reg         (fu_reg),
    .fu_val         (fu_val),
    .fu_rob_entry   (fu_rob_entry),
    .slot_busy      (slot_busy),
    .ring_valid     (ring_valid),
    .ring_reg       (ring_reg),
    .ring_val       (ring_val),
    .ring_rob_entry (ring_rob_entry),
    .count          (count),
    .starve         (starve)
  );

  // Reference model: a queue of pending results, the last injected packet,
  // and a run length of consecutive blocked cycles.
  logic [47:0] m_q[$];
  logic        m_rv;
  logic [47:0] m_data;
  int          m_blk;
  bit          ready_exp;
  bit          ready_seen;

  wire [52:0] dut_vec = {ring_valid, ring_reg, ring_val, ring_rob_entry, count, starve};

  function automatic logic [52:0] exp_vec();
    return {m_rv, m_data, 3'(m_q.size()), (m_blk == LIMIT)};
  endfunction

  function automatic logic [47:0] rpkt();
    return {8'($urandom), 32'($urandom), 8'($urandom)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rv   = 1'b0;
    m_data = '0;
    m_blk  = 0;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic tick(input bit v, input bit busy, input bit fl, input logic [47:0] pkt);
    int size;
    bit acc;
    bit byp;
    fu_valid  = v;
    slot_busy = busy;
    flush     = fl;
    {fu_reg, fu_val, fu_rob_entry} = pkt;
    #1;
    ready_seen = fu_ready;
    size      = m_q.size();
    ready_exp = !fl && (size < DEPTH);
    acc       = v && ready_exp;
    byp       = BYP && (size == 0) && acc && !busy;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_rv  = 1'b0;
      m_blk = 0;
    end else begin
      if (size > 0 && !busy) begin
        m_data = m_q.pop_front();
        m_rv   = 1'b1;
      end else if (byp) begin
        m_data = pkt;
        m_rv   = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (size == 0 || !busy) m_blk = 0;
      else if (m_blk < LIMIT) m_blk++;
      if (acc && !byp) m_q.push_back(pkt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = 1'b0; slot_busy = 1'b0;
    fu_reg = '0; fu_val = '0; fu_rob_entry = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    checks++;
    if (fu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b expected 0", fu_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fu_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset: got %b expected 1", fu_ready);
    end
  endtask

  task automatic test_single();
    logic [47:0] p = {8'd5, 32'hDEAD_BEEF, 8'd12};
    tick(1'b1, 1'b0, 1'b0, p);
    checks++;
`ifdef RING_TX_BYPASS_EN
    if ({ring_valid, ring_reg, ring_val, ring_rob_entry} !== {1'b1, p}) begin
      failures++; $display("FAIL single_edge1: got %h expected %h", {ring_valid, ring_reg, ring_val, ring_rob_entry}, {1'b1, p});
    end
`else
    if (ring_valid !== 1'b0) begin
      failures++; $display("FAIL single_edge1: got %b expected 0", ring_valid);
    end
`endif
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
`ifdef RING_TX_BYPASS_EN
    if (ring_valid !== 1'b0) begin
      failures++; $display("FAIL single_edge2: got %b expected 0", ring_valid);
    end
`else
    if ({ring_valid, ring_reg, ring_val, ring_rob_entry} !== {1'b1, p}) begin
      failures++; $display("FAIL single_edge2: got %h expected %h", {ring_valid, ring_reg, ring_val, ring_rob_entry}, {1'b1, p});
    end
`endif
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (ring_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL single_edge3: got valid=%b count=%0d expected 0/0", ring_valid, count);
    end
  endtask

  task automatic test_fill();
    logic [47:0] exp[5];
    for (int i = 0; i < 4; i++) begin
      exp[i] = rpkt();
      tick(1'b1, 1'b1, 1'b0, exp[i]);
    end
    checks++;
    if (count !== 3'd4 || fu_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full: got count=%0d ready=%b expected 4/0", count, fu_ready);
    end
    exp[4] = rpkt();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, exp[4]);
      checks++;
      if (ready_seen !== 1'b0 || count !== 3'd4) begin
        failures++; $display("FAIL fill_hold: got ready=%b count=%0d expected 0/4", ready_seen, count);
      end
    end
    // The 5th offer stays up; it is taken the edge after the first pop.
    for (int i = 0; i < 5; i++) begin
      tick(i < 2, 1'b0, 1'b0, exp[4]);
      checks++;
      if ({ring_valid, ring_reg, ring_val, ring_rob_entry} !== {1'b1, exp[i]}) begin
        failures++; $display("FAIL fill_drain_%0d: got %h expected %h", i, {ring_valid, ring_reg, ring_val, ring_rob_entry}, {1'b1, exp[i]});
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL fill_model: got %h expected %h", dut_vec, exp_vec());
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_starve();
    logic [47:0] p = rpkt();
    tick(1'b1, 1'b1, 1'b0, p);
    for (int k = 1; k <= 11; k++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (starve !== (k >= LIMIT)) begin
        failures++; $display("FAIL starve_blk%0d: got %b expected %b", k, starve, (k >= LIMIT));
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if ({starve, ring_valid, ring_reg, ring_val, ring_rob_entry} !== {2'b01, p}) begin
      failures++; $display("FAIL starve_pop: got %h expected %h", {starve, ring_valid, ring_reg, ring_val, ring_rob_entry}, {2'b01, p});
    end
  endtask

  task automatic test_interleave();
    logic [47:0] exp[$];
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      exp.push_back(rpkt());
      tick(1'b1, 1'b1, 1'b0, exp[i]);
    end
    for (int c = 0; c < 8; c++) begin
      tick(1'b0, (c % 2) == 0, 1'b0, '0);
      checks++;
      if (ring_valid !== ((c % 2) == 1 && seen < 3)) begin
        failures++; $display("FAIL inter_valid_c%0d: got %b expected %b", c, ring_valid, ((c % 2) == 1 && seen < 3));
      end
      if (ring_valid === 1'b1 && seen < 3) begin
        checks++;
        if ({ring_reg, ring_val, ring_rob_entry} !== exp[seen]) begin
          failures++; $display("FAIL inter_data_%0d: got %h expected %h", seen, {ring_reg, ring_val, ring_rob_entry}, exp[seen]);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 3 || count !== 3'd0) begin
      failures++; $display("FAIL inter_total: got %0d pulses count=%0d expected 3/0", seen, count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, rpkt());
    tick(1'b1, 1'b0, 1'b1, rpkt());
    checks++;
    if (ready_seen !== 1'b0 || count !== 3'd0 || ring_valid !== 1'b0) begin
      failures++; $display("FAIL flush_edge: got ready=%b count=%0d valid=%b expected 0/0/0", ready_seen, count, ring_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (ring_valid !== 1'b0 || count !== 3'd0) begin
        failures++; $display("FAIL flush_stale_%0d: got valid=%b count=%0d expected 0/0", i, ring_valid, count);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 1'b0, rpkt());
    tick(1'b1, 1'b1, 1'b0, rpkt());
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (dut_vec !== exp_vec() || ring_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: got %h expected %h", dut_vec, exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== '0 || fu_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_async: got %h ready=%b expected 0/0", dut_vec, fu_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (fu_ready !== 1'b1 || count !== 3'd0) begin
      failures++; $display("FAIL rstmid_release: got ready=%b count=%0d expected 1/0", fu_ready, count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tick(($urandom % 4) != 0, (c % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 3) == 0),
           ($urandom % 50) == 0, rpkt());
      checks++;
      if (ready_seen !== ready_exp) begin
        failures++; $display("FAIL rand_ready_c%0d: got %b expected %b", c, ready_seen, ready_exp);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL rand_state_c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_starve();
    test_interleave();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_stop_tx.md
# ring_stop_tx

Injection port for one functional unit on the result-broadcast ring. It accepts completed results (physical reg, value, ROB entry) from its FU via a valid/ready handshake and buffers them in a small FIFO. It places one result onto the ring at a time, only when the ring slot passing its stop is empty, so results are never dropped. One instance sits between each FU (logical, arithmetic, branch, ld_st, mul_div) and its ring position.

## Interface
- XLEN, 32, result value width
- PHYS_REG_SIZE, 256, physical registers; tag width PW = $clog2(PHYS_REG_SIZE)
- ROB_ENTRY, 256, ROB entries; RW = $clog2(ROB_ENTRY)
- DEPTH, 4, FIFO entries, power of two, ≥2
- STARVE_LIMIT, 8, consecutive blocked cycles before `starve` asserts
- Reset and clock: `rst` is asynchronous and active-high; the clock is `clk`. These are listed first below.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous discard of all buffered and outgoing results
- fu_valid  in  1  FU offers a result
- fu_ready  out  1  port can accept
- fu_reg / fu_val / fu_rob_entry  in  PW / XLEN / RW  offered result
- slot_busy  in  1  the ring slot arriving at this stop at the next edge is occupied
- ring_valid  out  1  registered; injects a result into this stop's ring slot
- ring_reg / ring_val / ring_rob_entry  out  PW / XLEN / RW  registered injected result
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- starve  out  1  head blocked ≥ STARVE_LIMIT consecutive cycles; upstream stops may hold off on it

## Operation
- Push: at an edge with `fu_valid && fu_ready`, the result is written at the tail.
- `fu_ready = !rst && !flush && count < DEPTH`. It is computed from the current count only. A pop in the same cycle does not free space, so a full FIFO refuses a push even when it is popping.
- Inject: at an edge with `count>0 && !slot_busy && !flush`, the head is popped into the ring_* registers and `ring_valid` goes to 1.
- Otherwise `ring_valid` goes to 0 at that edge. The ring_* data registers hold their previous value.
- Push and pop in the same edge are both performed; count is unchanged.
- Order is strict FIFO. Results are never reordered or dropped, except by `flush`.
- Starve counter: increments, saturating at STARVE_LIMIT, at each edge where `count>0 && slot_busy`. It clears at each edge that performs a pop, and on any edge where count==0.
- `starve = (starve_cnt == STARVE_LIMIT)`.
- Flush: at the edge where flush=1, count becomes 0, the pointers go to 0, ring_valid becomes 0, and starve_cnt becomes 0. A push presented in that cycle is refused.
- Reset values: ring_valid=0, ring_reg/val/rob_entry=0, count=0, starve=0, pointers=0. `fu_ready` is 0 while rst=1.
- Reset mid-operation discards everything immediately, asynchronously.

## Timing
- Baseline latency: a result accepted at edge N can appear on ring_valid after edge N+1 at the earliest. The FIFO write and the ring register load are separate edges.
- Blocking: each cycle with slot_busy=1 delays the head by exactly one cycle.
- Throughput: with slot_busy held at 0, one injection per cycle.
- ring_valid is a one-cycle pulse per result. Back-to-back results give consecutive high cycles.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

## Configuration
- `RING_TX_BYPASS_EN` defined: when `count==0 && fu_valid && fu_ready && !slot_busy && !flush`, the FU result loads directly into the ring_* registers at edge N. It is not written to the FIFO, and ring_valid is high after edge N, for a latency of 1.
- `RING_TX_BYPASS_EN` undefined: every result passes through the FIFO, for a latency of ≥2.
- Order is preserved either way. Bypass is only possible when the FIFO is empty.

## Structure
- Shared package `ring_pkg`:
  - `ring_pkt_t` struct {reg, val, rob_entry}
  - width localparams PW, RW
  - ring position constants (ROB=0, LOGICAL=1 … REG_FILE=6)
- Sub-module `ring_tx_fifo`:
  - DEPTH-entry circular buffer of ring_pkt_t
  - head/tail pointers, count, push/pop/flush ports, head data output
- The top level holds the inject control, the ring output registers, the starve counter and the bypass path.

## Test plan
- Single result, idle ring: push {reg=5, val=0xDEAD_BEEF, rob=12} at edge 1 with slot_busy=0.
  - Without bypass: ring_valid is high for exactly the cycle after edge 2, carrying those values.
  - With bypass: ring_valid is high after edge 1.
- Fill with slot_busy=1: push 4 results.
  - count=4 and fu_ready=0.
  - A 5th offer is held (not accepted) until the first pop.
  - After slot_busy drops, 4 consecutive ring_valid pulses follow in push order.
- Starvation: hold one entry with slot_busy=1.
  - starve=1 after the 8th blocked edge and stays 1.
  - It clears at the edge that pops.
- Interleaved blocking: alternate slot_busy 1/0 with 3 entries queued.
  - Injections occur only on the slot_busy=0 cycles.
  - No loss and no duplication.
- Flush while count=3 and a push is offered:
  - count=0 and ring_valid=0 next cycle.
  - The offered result is not accepted.
  - No later injection of stale data.
- Async reset mid-injection with ring_valid=1:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - After release, fu_ready=1 and count=0.
